// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : IF/ID/EX sequencing and hazard controller with stall/flush
//               performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int REG_ADDR_W     = 5,
    parameter int XLEN           = 32,
    parameter int BRANCH_PENALTY = 2,
    parameter int CNT_W          = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_mem_read_i,
    input  logic                  ex_branch_taken_i,
    input  logic [XLEN-1:0]       ex_branch_target_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ready_i,
    output logic                  pc_incr_en_o,
    output logic                  pc_redirect_o,
    output logic [XLEN-1:0]       pc_target_o,
    output logic                  id_stall_o,
    output logic                  id_flush_o,
    output logic                  ex_stall_o,
    output logic                  ex_bubble_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_FLUSH    = 2'd3
    } state_t;

    localparam logic [3:0] c_PEN_INIT = 4'(BRANCH_PENALTY - 1);

    state_t           r_state;
    logic [3:0]       r_pen;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    state_t     w_next;
    logic [3:0] w_pen_next;
    logic       w_load_use;
    logic       w_mem_wait;
    logic       w_hold;
    logic       w_incr;
    logic       w_redirect;
    logic       w_id_stall;
    logic       w_id_flush;
    logic       w_ex_stall;
    logic       w_ex_bubble;

    assign w_load_use = ex_mem_read_i && (ex_rd_i != '0) &&
                        ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                         (id_rs2_used_i && (id_rs2_i == ex_rd_i)));
    assign w_mem_wait = mem_req_i && !mem_ready_i;

    // MEM_WAIT only releases on ready; then the cycle is judged like RUN.
    assign w_hold = (r_state == ST_RUN) ? w_mem_wait : !mem_ready_i;

    always_comb begin
        w_next      = r_state;
        w_pen_next  = r_pen;
        w_incr      = 1'b0;
        w_redirect  = 1'b0;
        w_id_stall  = 1'b0;
        w_id_flush  = 1'b0;
        w_ex_stall  = 1'b0;
        w_ex_bubble = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) w_next = ST_RUN;
            end
            ST_RUN, ST_MEM_WAIT: begin
                if (w_hold) begin
                    w_id_stall = 1'b1;
                    w_ex_stall = 1'b1;
                    w_next     = ST_MEM_WAIT;
                end else if (ex_branch_taken_i) begin
                    w_redirect  = 1'b1;
                    w_id_flush  = 1'b1;
                    w_ex_bubble = 1'b1;
                    if (BRANCH_PENALTY > 1) begin
                        w_next     = ST_FLUSH;
                        w_pen_next = c_PEN_INIT;
                    end else begin
                        w_next = ST_RUN;
                    end
                end else if (w_load_use) begin
                    w_id_stall  = 1'b1;
                    w_ex_bubble = 1'b1;
                    w_next      = ST_RUN;
                end else begin
                    w_incr = 1'b1;
                    w_next = ST_RUN;
                end
            end
            ST_FLUSH: begin
                w_incr      = 1'b1;
                w_id_flush  = 1'b1;
                w_ex_bubble = 1'b1;
                w_pen_next  = r_pen - 4'd1;
                if (r_pen <= 4'd1) w_next = ST_RUN;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pen       <= 4'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next;
            r_pen   <= w_pen_next;
            if ((r_state != ST_IDLE) && !w_incr && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_redirect && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    // Gate with rst so controls are quiet for the whole reset pulse.
    assign pc_incr_en_o  = w_incr      && !rst;
    assign pc_redirect_o = w_redirect  && !rst;
    assign id_stall_o    = w_id_stall  && !rst;
    assign id_flush_o    = w_id_flush  && !rst;
    assign ex_stall_o    = w_ex_stall  && !rst;
    assign ex_bubble_o   = w_ex_bubble && !rst;
    assign pc_target_o   = pc_redirect_o ? ex_branch_target_i : '0;
    assign stall_cnt_o   = r_stall_cnt;
    assign flush_cnt_o   = r_flush_cnt;
    assign state_o       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed and randomized checks of pipeline_ctrl against a
//               cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int PEN        = 2;
    localparam int CNT_W      = 5;
    localparam int SAT        = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start_i;
    logic [REG_ADDR_W-1:0] id_rs1_i, id_rs2_i, ex_rd_i;
    logic                  id_rs1_used_i, id_rs2_used_i, ex_mem_read_i;
    logic                  ex_branch_taken_i;
    logic [XLEN-1:0]       ex_branch_target_i;
    logic                  mem_req_i, mem_ready_i;
    logic                  pc_incr_en_o, pc_redirect_o, id_stall_o, id_flush_o;
    logic                  ex_stall_o, ex_bubble_o;
    logic [XLEN-1:0]       pc_target_o;
    logic [CNT_W-1:0]      stall_cnt_o, flush_cnt_o;
    logic [1:0]            state_o;

    pipeline_ctrl #(
        .REG_ADDR_W(REG_ADDR_W), .XLEN(XLEN), .BRANCH_PENALTY(PEN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .ex_rd_i(ex_rd_i), .ex_mem_read_i(ex_mem_read_i),
        .ex_branch_taken_i(ex_branch_taken_i), .ex_branch_target_i(ex_branch_target_i),
        .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
        .pc_incr_en_o(pc_incr_en_o), .pc_redirect_o(pc_redirect_o),
        .pc_target_o(pc_target_o), .id_stall_o(id_stall_o), .id_flush_o(id_flush_o),
        .ex_stall_o(ex_stall_o), .ex_bubble_o(ex_bubble_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pipeline mode (0 idle, 1 run, 2 mem wait, 3 flush),
    // remaining flush cycles, and plain integer counters.
    int m_mode, m_flush_left, m_stall, m_flushes;
    int n_mode, n_flush_left;
    logic e_incr, e_redir, e_ids, e_idf, e_exs, e_exb;
    logic [XLEN-1:0] e_tgt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        logic lu, waiting;
        lu = ex_mem_read_i && (ex_rd_i != 0) &&
             ((id_rs1_used_i && id_rs1_i == ex_rd_i) || (id_rs2_used_i && id_rs2_i == ex_rd_i));
        {e_incr, e_redir, e_ids, e_idf, e_exs, e_exb} = '0;
        e_tgt        = '0;
        n_mode       = m_mode;
        n_flush_left = m_flush_left;
        if (m_mode == 0) begin
            if (start_i) n_mode = 1;
        end else if (m_mode == 3) begin
            e_incr = 1; e_idf = 1; e_exb = 1;
            n_flush_left = m_flush_left - 1;
            n_mode = (n_flush_left == 0) ? 1 : 3;
        end else begin
            waiting = (m_mode == 1) ? (mem_req_i && !mem_ready_i) : !mem_ready_i;
            if (waiting) begin
                e_ids = 1; e_exs = 1; n_mode = 2;
            end else if (ex_branch_taken_i) begin
                e_redir = 1; e_tgt = ex_branch_target_i; e_idf = 1; e_exb = 1;
                n_flush_left = PEN - 1;
                n_mode = (PEN > 1) ? 3 : 1;
            end else if (lu) begin
                e_ids = 1; e_exb = 1; n_mode = 1;
            end else begin
                e_incr = 1; n_mode = 1;
            end
        end
    endtask

    task automatic model_commit();
        if (m_mode != 0 && !e_incr && m_stall < SAT) m_stall++;
        if (e_redir && m_flushes < SAT) m_flushes++;
        m_mode       = n_mode;
        m_flush_left = n_flush_left;
    endtask

    task automatic model_reset();
        m_mode = 0; m_flush_left = 0; m_stall = 0; m_flushes = 0;
    endtask

    task automatic clr_in();
        start_i = 0; id_rs1_i = 0; id_rs2_i = 0; ex_rd_i = 0;
        id_rs1_used_i = 0; id_rs2_used_i = 0; ex_mem_read_i = 0;
        ex_branch_taken_i = 0; ex_branch_target_i = 0; mem_req_i = 0; mem_ready_i = 0;
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cyc();
        #1;
        model_eval();
        chk("incr",    pc_incr_en_o,  e_incr);
        chk("redir",   pc_redirect_o, e_redir);
        chk("target",  pc_target_o,   e_tgt);
        chk("idstall", id_stall_o,    e_ids);
        chk("idflush", id_flush_o,    e_idf);
        chk("exstall", ex_stall_o,    e_exs);
        chk("exbub",   ex_bubble_o,   e_exb);
        chk("state",   state_o,       m_mode);
        chk("stallcnt", stall_cnt_o,  m_stall);
        chk("flushcnt", flush_cnt_o,  m_flushes);
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must drop immediately.
    task automatic do_reset();
        #2 rst = 1;
        #1;
        chk("rst_ctrl", {pc_incr_en_o, pc_redirect_o, id_stall_o, id_flush_o,
                         ex_stall_o, ex_bubble_o}, 0);
        chk("rst_tgt",   pc_target_o, 0);
        chk("rst_state", state_o, 0);
        chk("rst_cnt",   {stall_cnt_o, flush_cnt_o}, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic reset_and_start();
        do_reset();
        clr_in();
        start_i = 1;
        cyc();
        start_i = 0;
    endtask

    initial begin
        clr_in();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 0;

        // 1: reset in the middle of a flush window, then restart
        start_i = 1; cyc(); start_i = 0;
        ex_branch_taken_i = 1; ex_branch_target_i = 32'h100; cyc(); clr_in();
        chk("t1_in_flush", state_o, 3);
        do_reset();
        start_i = 1; #1;
        chk("t1_idle_incr", pc_incr_en_o, 0);
        cyc(); start_i = 0;
        chk("t1_run", state_o, 1);
        #1 chk("t1_incr", pc_incr_en_o, 1);
        cyc();

        // 2: load-use bubble, then same pattern against x0
        ex_mem_read_i = 1; ex_rd_i = 5; id_rs2_i = 5; id_rs2_used_i = 1;
        #1 chk("t2_lu", {pc_incr_en_o, id_stall_o, ex_bubble_o}, 3'b011);
        cyc(); clr_in();
        chk("t2_stallcnt", stall_cnt_o, 1);
        #1 chk("t2_after", pc_incr_en_o, 1);
        cyc();
        ex_mem_read_i = 1; ex_rd_i = 0; id_rs2_i = 0; id_rs2_used_i = 1;
        #1 chk("t2_x0", pc_incr_en_o, 1);
        cyc(); clr_in();

        // 3: taken branch with two-cycle penalty
        ex_branch_taken_i = 1; ex_branch_target_i = 32'h40;
        #1 chk("t3_c0", {pc_redirect_o, id_flush_o}, 2'b11);
        chk("t3_tgt", pc_target_o, 32'h40);
        cyc(); clr_in();
        chk("t3_c1_state", state_o, 3);
        #1 chk("t3_c1_flush", id_flush_o, 1);
        cyc();
        chk("t3_c2_state", state_o, 1);
        chk("t3_flushcnt", flush_cnt_o, 1);

        // 4: three-cycle memory wait
        reset_and_start();
        mem_req_i = 1; mem_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t4_wait", {pc_incr_en_o, id_stall_o, ex_stall_o}, 3'b011);
            cyc();
            chk("t4_state", state_o, 2);
        end
        mem_ready_i = 1;
        #1 chk("t4_ready_incr", pc_incr_en_o, 1);
        cyc(); clr_in();
        chk("t4_stallcnt", stall_cnt_o, 3);

        // 5: memory wait outranks branch and load-use
        reset_and_start();
        mem_req_i = 1; mem_ready_i = 0; ex_branch_taken_i = 1; ex_branch_target_i = 32'h80;
        ex_mem_read_i = 1; ex_rd_i = 3; id_rs1_i = 3; id_rs1_used_i = 1;
        #1 chk("t5_noredir", pc_redirect_o, 0);
        chk("t5_exstall", ex_stall_o, 1);
        cyc();
        mem_ready_i = 1;
        #1 chk("t5_redir", pc_redirect_o, 1);
        chk("t5_tgt", pc_target_o, 32'h80);
        cyc(); clr_in();

        // 6: stall counter saturation
        mem_req_i = 1;
        for (int i = 0; i < SAT + 3; i++) cyc();
        chk("t6_sat", stall_cnt_o, SAT);
        clr_in();
        cyc();

        // Randomized traffic with occasional resets
        reset_and_start();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            start_i            = ($urandom_range(0, 3) == 0);
            ex_mem_read_i      = $urandom_range(0, 1);
            ex_rd_i            = 5'($urandom_range(0, 3));
            id_rs1_i           = 5'($urandom_range(0, 3));
            id_rs2_i           = 5'($urandom_range(0, 3));
            id_rs1_used_i      = $urandom_range(0, 1);
            id_rs2_used_i      = $urandom_range(0, 1);
            ex_branch_taken_i  = ($urandom_range(0, 5) == 0);
            ex_branch_target_i = $urandom;
            mem_req_i          = ($urandom_range(0, 2) == 0);
            mem_ready_i        = $urandom_range(0, 1);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central sequencing/hazard controller for the in-order IF/ID/EX pipeline. It drives the fetch PC increment enable, per-stage stall/flush/bubble controls and the PC redirect from per-cycle hazard inputs: load-use, taken branch/jump, and data-memory wait. It also keeps saturating stall and flush performance counters. It sits beside if_stage, id_stage and ex_stage and owns all pipeline-advance decisions.

Parameters:
REG_ADDR_W, 5, register index width
XLEN, 32, PC/target width
BRANCH_PENALTY, 2, cycles of ID flush after a redirect (1..15)
CNT_W, 32, performance counter width

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
start_i  in  1  leave IDLE and begin fetching
id_rs1_i  in  REG_ADDR_W  rs1 of instruction in ID
id_rs2_i  in  REG_ADDR_W  rs2 of instruction in ID
id_rs1_used_i  in  1  ID instruction reads rs1
id_rs2_used_i  in  1  ID instruction reads rs2
ex_rd_i  in  REG_ADDR_W  rd of instruction in EX
ex_mem_read_i  in  1  EX instruction is a load
ex_branch_taken_i  in  1  EX resolved taken branch/jump
ex_branch_target_i  in  XLEN  redirect target
mem_req_i  in  1  data-memory request from EX
mem_ready_i  in  1  data-memory completes this cycle
pc_incr_en_o  out  1  if_stage advances PC
pc_redirect_o  out  1  if_stage loads pc_target_o
pc_target_o  out  XLEN  redirect address
id_stall_o  out  1  ID holds its register
id_flush_o  out  1  ID register loads NOP
ex_stall_o  out  1  EX holds its register
ex_bubble_o  out  1  EX register loads NOP
stall_cnt_o  out  CNT_W  cycles with pc_incr_en_o=0 while not IDLE
flush_cnt_o  out  CNT_W  number of redirects
state_o  out  2  IDLE=0 RUN=1 MEM_WAIT=2 FLUSH=3

Behaviour:
- Reset (async, any time, including mid-FLUSH/MEM_WAIT): state=IDLE, penalty counter=0, both perf counters=0. Every control output 0 while rst is high. pc_target_o=0.
- Outputs are combinational (Mealy) from state and current inputs. State and counters update on posedge clk.
- load_use = ex_mem_read_i & (ex_rd_i!=0) & ((id_rs1_used_i & id_rs1_i==ex_rd_i) | (id_rs2_used_i & id_rs2_i==ex_rd_i)).
- mem_wait = mem_req_i & ~mem_ready_i.
- IDLE: all controls 0. Goes to RUN on the cycle after start_i=1.
- RUN: evaluate in priority order.
  - mem_wait: pc_incr_en_o=0, id_stall_o=1, ex_stall_o=1. Next state MEM_WAIT. EX is frozen, so a simultaneous ex_branch_taken_i is ignored and re-seen after the wait.
  - ex_branch_taken_i: pc_redirect_o=1, pc_target_o=ex_branch_target_i, pc_incr_en_o=0, id_flush_o=1, ex_bubble_o=1. flush_cnt++. If BRANCH_PENALTY>1, next state FLUSH with counter=BRANCH_PENALTY-1; otherwise stay in RUN.
  - load_use: pc_incr_en_o=0, id_stall_o=1, ex_bubble_o=1. Stay in RUN. This is exactly one bubble per load-use.
  - none of the above: pc_incr_en_o=1, all other controls 0.
- MEM_WAIT: while mem_ready_i=0, same outputs as the RUN mem_wait case. On the cycle mem_ready_i=1, apply the normal RUN evaluation with mem_wait forced false, and next state follows that result (RUN or FLUSH).
- FLUSH: pc_incr_en_o=1, id_flush_o=1, ex_bubble_o=1. Counter decrements each cycle; return to RUN when counter reaches 1.
  - A new ex_branch_taken_i in FLUSH is impossible (EX is bubbled). If asserted anyway, it is ignored.
- pc_target_o holds ex_branch_target_i only while pc_redirect_o=1; otherwise it is 0.
- stall_cnt increments on every non-IDLE cycle with pc_incr_en_o=0. Both counters saturate at all-ones and do not wrap.
- start_i is ignored outside IDLE.

Test Plan:
1. rst pulse mid-FLUSH, then start_i=1 for one cycle -> state IDLE during reset with all outputs 0 and counters 0; RUN on the next clk; pc_incr_en_o=1.
2. RUN, ex_mem_read_i=1, ex_rd_i=5, id_rs2_i=5, id_rs2_used_i=1 -> exactly one cycle of pc_incr_en_o=0, id_stall_o=1, ex_bubble_o=1; stall_cnt_o=1. Repeat with ex_rd_i=0 -> no stall.
3. RUN, ex_branch_taken_i=1, target 0x0000_0040, BRANCH_PENALTY=2 -> cycle0: pc_redirect_o=1, pc_target_o=0x40, id_flush_o=1; cycle1: state FLUSH, id_flush_o=1; cycle2: RUN. flush_cnt_o=1.
4. mem_req_i=1 with mem_ready_i low for 3 cycles, then high -> 3 cycles of id_stall_o=ex_stall_o=1 and pc_incr_en_o=0 (state MEM_WAIT after the first); the ready cycle gives pc_incr_en_o=1; stall_cnt_o=3.
5. mem_wait, ex_branch_taken_i and load_use all asserted in the same cycle -> mem stall only, no redirect. After ready with the branch still asserted -> redirect occurs.
6. Force stall_cnt to all-ones minus 1, then stall 3 cycles -> counter holds at all-ones.
